axilite_wb_master: RTL

- AXI-Lite slave to Wishbone master bridge: converts AXI-Lite register accesses into single Wishbone classic cycles.
- Converts in the opposite direction to the existing Wishbone-to-AXI-Lite bridge on the FIR control path.
- Lets an AXI-Lite initiator (e.g. a DMA descriptor engine or test master) reach Wishbone slaves such as the SDRAM arbiter port or the DMA register file.
- Adds a base-address offset, round-robin read/write arbitration and a no-ack timeout.

---
 rtl/axilite_wb_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axilite_wb_master.sv
// rtl/axilite_wb_master.sv - AXI-Lite slave to Wishbone classic master bridge
module axilite_wb_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 12,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic [31:0]           wbm_dat_i,
  output logic                  err_o
);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WB_WR, WB_RD, RD_RESP} state_t;

  state_t      state_q, state_d;
  logic        aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic        rr_wr_q, rr_wr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d, err_q, err_d;
  logic        aw_rdy, w_rdy, ar_rdy, wr_req;
  logic        aw_fire, w_fire, ar_fire;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  // rr_wr_q = 1 means a contending write wins the next IDLE arbitration
  always_comb begin
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    ar_rdy = 1'b0;
    wr_req = awvalid | wvalid;
    if (state_q == IDLE) begin
      if (wr_req && arvalid) begin
        aw_rdy = rr_wr_q;
        w_rdy  = rr_wr_q;
        ar_rdy = ~rr_wr_q;
      end else begin
        aw_rdy = 1'b1;
        w_rdy  = 1'b1;
        ar_rdy = ~wr_req;
      end
    end else if (state_q == WR_WAIT) begin
      aw_rdy = ~aw_cap_q;
      w_rdy  = ~w_cap_q;
    end
  end

  assign awready = axis_rst_n & aw_rdy;
  assign wready  = axis_rst_n & w_rdy;
  assign arready = axis_rst_n & ar_rdy;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign ar_fire = arvalid & arready;

  always_comb begin
    state_d  = state_q;
    aw_cap_d = aw_cap_q;
    w_cap_d  = w_cap_q;
    rr_wr_d  = rr_wr_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE, WR_WAIT: begin
        if (aw_fire) begin
          aw_cap_d = 1'b1;
          adr_d    = BASE_ADDR | 32'({awaddr[ADDR_WIDTH-1:2], 2'b00});
        end
        if (w_fire) begin
          w_cap_d = 1'b1;
          dat_d   = wdata;
        end
        if (state_q == IDLE && (aw_fire || w_fire)) rr_wr_d = ~rr_wr_q;
        if (aw_cap_d && w_cap_d) begin
          state_d = WB_WR;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 4'hF;
          cnt_d   = 8'd0;
        end else if (aw_cap_d || w_cap_d) begin
          state_d = WR_WAIT;
        end else if (ar_fire) begin
          rr_wr_d = ~rr_wr_q;
          state_d = WB_RD;
          adr_d   = BASE_ADDR | 32'({araddr[ADDR_WIDTH-1:2], 2'b00});
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          cnt_d   = 8'd0;
        end
      end
      WB_WR, WB_RD: begin
        // an ack arriving on the expiry edge still completes the access normally
        if (wbm_ack_i || cnt_q == 8'(TIMEOUT - 1)) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
          err_d = ~wbm_ack_i;
          if (state_q == WB_WR) begin
            state_d  = IDLE;
            aw_cap_d = 1'b0;
            w_cap_d  = 1'b0;
          end else begin
            state_d  = RD_RESP;
            rvalid_d = 1'b1;
            rdata_d  = wbm_ack_i ? wbm_dat_i : 32'hFFFF_FFFF;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q  <= IDLE;
      aw_cap_q <= 1'b0;
      w_cap_q  <= 1'b0;
      rr_wr_q  <= 1'b0;
      cnt_q    <= 8'd0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 4'h0;
      adr_q    <= 32'd0;
      dat_q    <= 32'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aw_cap_q <= aw_cap_d;
      w_cap_q  <= w_cap_d;
      rr_wr_q  <= rr_wr_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign err_o     = err_q;

endmodule
